// File: rtl/ravenoc_buf_pkg.sv
// Shared definitions for the router input VC buffer: flit framing types and
// request-bus field positions.
package ravenoc_buf_pkg;

  localparam int NUM_VC    = 2;
  localparam int REQ_W     = 37;
  localparam int VALID_BIT = 0;
  localparam int VC_BIT    = 2;
  localparam int TYPE_MSB  = 33;
  localparam int TYPE_LSB  = 32;
  localparam int FLIT_LSB  = 3;
  localparam int DATA_W    = REQ_W - FLIT_LSB;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    FR_IDLE   = 1'b0,
    FR_IN_PKT = 1'b1
  } frame_state_e;

endpackage

// File: rtl/input_vc_buffer_vc_fifo.sv
// Single virtual-channel flit FIFO with a power-of-two depth and an
// occupancy count one bit wider than the pointers.
module vc_fifo
  import ravenoc_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = DATA_W
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           data,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Head is read straight from storage so a flit is visible the cycle after its push.
  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/input_vc_buffer.sv
// Per-VC input buffer in front of input_router: one FIFO and framing checker
// per VC, round-robin head selection onto the request bus, credit return on pop.
module input_vc_buffer #(
  parameter int NUM_VC = ravenoc_buf_pkg::NUM_VC,
  parameter int DEPTH  = 4,
  parameter int REQ_W  = ravenoc_buf_pkg::REQ_W
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              in_valid_i,
  input  logic              in_vc_i,
  input  logic [REQ_W-1:0]  in_flit_i,
  output logic [NUM_VC-1:0] in_ready_o,
  output logic [REQ_W-1:0]  out_req_o,
  input  logic              out_ack_i,
  output logic [NUM_VC-1:0] credit_o,
  output logic              err_o,
  output logic              err_vc_o
);
  import ravenoc_buf_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = REQ_W - FLIT_LSB;

  logic [NUM_VC-1:0] push_v;
  logic [NUM_VC-1:0] pop_v;
  logic [NUM_VC-1:0] nonempty_next;
  logic [NUM_VC-1:0] frame_err;
  logic [CW-1:0]     count      [NUM_VC];
  logic [CW-1:0]     count_next [NUM_VC];
  logic [DW-1:0]     head       [NUM_VC];

  logic       push;
  logic       pop;
  logic       drop;
  logic       sel_valid_reg, sel_valid_next;
  logic       sel_vc_reg, sel_vc_next;
  logic       err_reg, err_vc_reg, frame_seen_reg;
  logic       unused_bits;
  flit_type_e in_type;

  assign push        = in_valid_i && in_ready_o[in_vc_i];
  assign drop        = in_valid_i && !in_ready_o[in_vc_i];
  assign pop         = sel_valid_reg && out_ack_i;
  assign in_type     = flit_type_e'(in_flit_i[TYPE_MSB:TYPE_LSB]);
  assign unused_bits = ^in_flit_i[FLIT_LSB-1:0];

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    frame_state_e state_reg, state_next;
    logic         bad_flit;

    assign in_ready_o[gi]    = (count[gi] != CW'(DEPTH));
    assign push_v[gi]        = push && (in_vc_i == 1'(gi));
    assign pop_v[gi]         = pop && (sel_vc_reg == 1'(gi));
    assign count_next[gi]    = count[gi] + CW'(push_v[gi]) - CW'(pop_v[gi]);
    assign nonempty_next[gi] = (count_next[gi] != '0);

    vc_fifo #(
      .DEPTH(DEPTH),
      .W    (DW)
    ) u_fifo (
      .clk  (clk),
      .srst (arst),
      .push (push_v[gi]),
      .pop  (pop_v[gi]),
      .data (in_flit_i[REQ_W-1:FLIT_LSB]),
      .head (head[gi]),
      .count(count[gi])
    );

    always_ff @(posedge clk) begin
      if (arst) state_reg <= FR_IDLE;
      else      state_reg <= state_next;
    end

    // Malformed flits still move the tracker so it resynchronises on the next packet.
    always_comb begin
      state_next = state_reg;
      if (push_v[gi]) begin
        case (state_reg)
          FR_IDLE:   if (in_type == FLIT_HEAD) state_next = FR_IN_PKT;
          FR_IN_PKT: if (in_type == FLIT_TAIL || in_type == FLIT_HEAD_TAIL) state_next = FR_IDLE;
          default:   state_next = FR_IDLE;
        endcase
      end
    end

    always_comb begin
      bad_flit = 1'b0;
      if (push_v[gi]) begin
        if (state_reg == FR_IDLE) bad_flit = (in_type == FLIT_BODY) || (in_type == FLIT_TAIL);
        else                      bad_flit = (in_type == FLIT_HEAD) || (in_type == FLIT_HEAD_TAIL);
      end
    end

    assign frame_err[gi] = bad_flit;
  end

  // sel_vc_reg doubles as the last grant, so the search starts at the other VC.
  always_comb begin
    sel_valid_next = sel_valid_reg;
    sel_vc_next    = sel_vc_reg;
    if (!sel_valid_reg || pop) begin
      sel_valid_next = |nonempty_next;
      if (nonempty_next[!sel_vc_reg]) sel_vc_next = !sel_vc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      sel_valid_reg <= 1'b0;
      sel_vc_reg    <= 1'b0;
    end else begin
      sel_valid_reg <= sel_valid_next;
      sel_vc_reg    <= sel_vc_next;
    end
  end

  // err_o also covers overflow drops; err_vc_o only records the first framing error.
  always_ff @(posedge clk) begin
    if (arst) begin
      err_reg        <= 1'b0;
      err_vc_reg     <= 1'b0;
      frame_seen_reg <= 1'b0;
    end else begin
      if (drop || |frame_err) err_reg <= 1'b1;
      if (|frame_err && !frame_seen_reg) begin
        frame_seen_reg <= 1'b1;
        err_vc_reg     <= in_vc_i;
      end
    end
  end

  always_comb begin
    out_req_o = '0;
    if (sel_valid_reg) begin
      out_req_o[REQ_W-1:FLIT_LSB] = head[sel_vc_reg];
      out_req_o[VC_BIT]           = sel_vc_reg;
      out_req_o[VALID_BIT]        = 1'b1;
    end
  end

  assign credit_o = pop_v & {NUM_VC{!arst}};
  assign err_o    = err_reg;
  assign err_vc_o = err_vc_reg;

endmodule

// File: tb/tb_input_vc_buffer.sv
// Bench for input_vc_buffer: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_input_vc_buffer;
  import ravenoc_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = REQ_W - FLIT_LSB;

  logic              clk        = 1'b0;
  logic              arst       = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_vc_i    = 1'b0;
  logic [REQ_W-1:0]  in_flit_i  = '0;
  logic [NUM_VC-1:0] in_ready_o;
  logic [REQ_W-1:0]  out_req_o;
  logic              out_ack_i  = 1'b0;
  logic [NUM_VC-1:0] credit_o;
  logic              err_o;
  logic              err_vc_o;

  int n_checks = 0;
  int n_pass   = 0;

  input_vc_buffer #(
    .NUM_VC(NUM_VC),
    .DEPTH (DEPTH),
    .REQ_W (REQ_W)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid_i(in_valid_i),
    .in_vc_i   (in_vc_i),
    .in_flit_i (in_flit_i),
    .in_ready_o(in_ready_o),
    .out_req_o (out_req_o),
    .out_ack_i (out_ack_i),
    .credit_o  (credit_o),
    .err_o     (err_o),
    .err_vc_o  (err_vc_o)
  );

  always #5 clk = ~clk;

  // Reference model: one queue of stored flits per VC plus the presented head.
  logic [DW-1:0] mq [2][$];
  bit m_sel_valid, m_sel_vc, m_err, m_err_vc, m_frame_seen;
  bit m_in_pkt [2];

  typedef struct {
    bit         chk;
    bit         rst;
    bit         v;
    bit         c;
    logic [1:0] ft;
    bit         a;
    bit         e_rv;
    bit         e_vc;
    logic [1:0] e_ty;
    logic [1:0] e_rdy;
    logic [1:0] e_cr;
    bit         e_err;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(bit chk, bit rst, bit v, bit c, logic [1:0] ft, bit a,
                              bit e_rv, bit e_vc, logic [1:0] e_ty, logic [1:0] e_rdy,
                              logic [1:0] e_cr, bit e_err);
    vec_t t;
    t.chk = chk; t.rst = rst; t.v = v; t.c = c; t.ft = ft; t.a = a;
    t.e_rv = e_rv; t.e_vc = e_vc; t.e_ty = e_ty; t.e_rdy = e_rdy; t.e_cr = e_cr; t.e_err = e_err;
    return t;
  endfunction

  function automatic logic [REQ_W-1:0] make_flit(input logic [1:0] ft);
    logic [REQ_W-1:0] f;
    f[31:0]                = $urandom();
    f[REQ_W-1:32]          = 5'($urandom());
    f[TYPE_MSB:TYPE_LSB]   = ft;
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_step();
    bit         popped, pushed, bad;
    int         v;
    logic [1:0] ft;
    if (arst) begin
      mq[0].delete();
      mq[1].delete();
      m_sel_valid = 0; m_sel_vc = 0; m_err = 0; m_err_vc = 0; m_frame_seen = 0;
      m_in_pkt[0] = 0; m_in_pkt[1] = 0;
      return;
    end
    v      = int'(in_vc_i);
    ft     = in_flit_i[TYPE_MSB:TYPE_LSB];
    popped = out_ack_i && m_sel_valid;
    pushed = in_valid_i && (mq[v].size() < DEPTH);
    if (in_valid_i && !pushed) m_err = 1;
    if (pushed) begin
      bad = m_in_pkt[v] ? (ft == 2'b00 || ft == 2'b11) : (ft == 2'b01 || ft == 2'b10);
      if (bad) begin
        m_err = 1;
        if (!m_frame_seen) begin
          m_frame_seen = 1;
          m_err_vc     = in_vc_i;
        end
      end
      m_in_pkt[v] = (ft == 2'b00) || (m_in_pkt[v] && ft == 2'b01);
      mq[v].push_back(in_flit_i[REQ_W-1:FLIT_LSB]);
    end
    if (popped) void'(mq[m_sel_vc].pop_front());
    if (!m_sel_valid || popped) begin
      if (mq[!m_sel_vc].size() > 0) begin
        m_sel_valid = 1;
        m_sel_vc    = !m_sel_vc;
      end else begin
        m_sel_valid = (mq[m_sel_vc].size() > 0);
      end
    end
  endtask

  task automatic check_model();
    logic [REQ_W-1:0] er;
    logic [1:0]       erdy, ecr;
    er = '0;
    if (m_sel_valid) er = {mq[m_sel_vc][0], m_sel_vc, 1'b0, 1'b1};
    erdy[0] = (mq[0].size() != DEPTH);
    erdy[1] = (mq[1].size() != DEPTH);
    ecr = 2'b00;
    if (out_ack_i && m_sel_valid && !arst) ecr[m_sel_vc] = 1'b1;
    check("rnd_req",    64'(out_req_o),  64'(er));
    check("rnd_ready",  64'(in_ready_o), 64'(erdy));
    check("rnd_credit", 64'(credit_o),   64'(ecr));
    check("rnd_err",    64'(err_o),      64'(m_err));
    check("rnd_err_vc", 64'(err_vc_o),   64'(m_err_vc));
  endtask

  task automatic apply(input logic r, input logic v, input logic c,
                       input logic [REQ_W-1:0] f, input logic a);
    arst = r; in_valid_i = v; in_vc_i = c; in_flit_i = f; out_ack_i = a;
    #3;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, '0, 0); advance();
    apply(1, 0, 0, '0, 0); advance();
  endtask

  logic [REQ_W-1:0] f3 [2][3];
  logic [1:0]       seq_ty [3];
  logic [1:0]       ecr;
  bit               r, vld, ack, vc;
  logic [1:0]       ty;

  initial begin
    //             chk rst v c ft    a  rv vc ty    rdy    cr     err
    tbl[0]  = mk(0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
    tbl[1]  = mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
    tbl[2]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
    tbl[3]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
    tbl[4]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
    tbl[5]  = mk(1, 0, 1, 0, 2'b11, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
    tbl[6]  = mk(1, 0, 0, 0, 2'b00, 1, 1, 0, 2'b11, 2'b11, 2'b01, 0);
    tbl[7]  = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
    tbl[8]  = mk(1, 0, 1, 1, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0);
    tbl[9]  = mk(1, 0, 1, 1, 2'b01, 0, 1, 1, 2'b00, 2'b11, 2'b00, 0);
    tbl[10] = mk(1, 0, 1, 1, 2'b01, 0, 1, 1, 2'b00, 2'b11, 2'b00, 0);
    tbl[11] = mk(1, 0, 1, 1, 2'b10, 0, 1, 1, 2'b00, 2'b11, 2'b00, 0);
    tbl[12] = mk(1, 0, 1, 1, 2'b11, 0, 1, 1, 2'b00, 2'b01, 2'b00, 0);
    tbl[13] = mk(1, 0, 0, 0, 2'b00, 1, 1, 1, 2'b00, 2'b01, 2'b10, 1);
    tbl[14] = mk(1, 0, 0, 0, 2'b00, 1, 1, 1, 2'b01, 2'b11, 2'b10, 1);
    tbl[15] = mk(1, 0, 0, 0, 2'b00, 1, 1, 1, 2'b01, 2'b11, 2'b10, 1);
    tbl[16] = mk(1, 0, 0, 0, 2'b00, 1, 1, 1, 2'b10, 2'b11, 2'b10, 1);
    tbl[17] = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 1);
    tbl[18] = mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 1);
    tbl[19] = mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 2'b11, 2'b00, 1);
    tbl[20] = mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 2'b11, 2'b00, 1);
    tbl[21] = mk(1, 0, 0, 0, 2'b00, 0, 1, 0, 2'b00, 2'b11, 2'b00, 1);
    tbl[22] = mk(1, 0, 0, 0, 2'b00, 1, 1, 0, 2'b00, 2'b11, 2'b01, 1);
    tbl[23] = mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b11, 2'b00, 1);

    // Directed table: single flit latency, VC1 overflow and drain, ack-low hold.
    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].c, make_flit(tbl[i].ft), tbl[i].a);
      if (tbl[i].chk) begin
        check($sformatf("row%0d_valid", i), 64'(out_req_o[VALID_BIT]), 64'(tbl[i].e_rv));
        if (tbl[i].e_rv) begin
          check($sformatf("row%0d_vc", i), 64'(out_req_o[VC_BIT]), 64'(tbl[i].e_vc));
          check($sformatf("row%0d_type", i), 64'(out_req_o[TYPE_MSB:TYPE_LSB]), 64'(tbl[i].e_ty));
        end else begin
          check($sformatf("row%0d_req_zero", i), 64'(out_req_o), 64'(0));
        end
        check($sformatf("row%0d_ready", i), 64'(in_ready_o), 64'(tbl[i].e_rdy));
        check($sformatf("row%0d_credit", i), 64'(credit_o), 64'(tbl[i].e_cr));
        check($sformatf("row%0d_err", i), 64'(err_o), 64'(tbl[i].e_err));
        $display("row %0d: valid=%b vc=%b type=%b ready=%b credit=%b err=%b",
                 i, out_req_o[VALID_BIT], out_req_o[VC_BIT], out_req_o[TYPE_MSB:TYPE_LSB],
                 in_ready_o, credit_o, err_o);
      end
      advance();
    end

    // Round-robin interleave of two three-flit packets, full-width hold while ack is low.
    do_reset();
    seq_ty[0] = 2'b00; seq_ty[1] = 2'b01; seq_ty[2] = 2'b10;
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 3; k++) begin
        f3[v][k] = make_flit(seq_ty[k]);
        apply(0, 1, 1'(v), f3[v][k], 0);
        if (v == 1) check("hold_req", 64'(out_req_o), 64'({f3[0][0][REQ_W-1:FLIT_LSB], 3'b001}));
        advance();
      end
    end
    for (int k = 0; k < 6; k++) begin
      apply(0, 0, 0, '0, 1);
      ecr = 2'b00;
      ecr[k % 2] = 1'b1;
      check($sformatf("rr%0d_req", k), 64'(out_req_o),
            64'({f3[k % 2][k / 2][REQ_W-1:FLIT_LSB], 1'(k % 2), 2'b01}));
      check($sformatf("rr%0d_credit", k), 64'(credit_o), 64'(ecr));
      $display("rr %0d: vc=%b type=%b credit=%b", k, out_req_o[VC_BIT],
               out_req_o[TYPE_MSB:TYPE_LSB], credit_o);
      advance();
    end
    apply(0, 0, 0, '0, 1);
    check("rr_drained_req", 64'(out_req_o), 64'(0));
    check("rr_drained_credit", 64'(credit_o), 64'(0));
    advance();

    // Framing errors: first error's VC is kept, later errors do not overwrite it.
    do_reset();
    apply(0, 1, 0, make_flit(2'b01), 0); advance();
    apply(0, 0, 0, '0, 0);
    check("frame_body_idle_err", 64'(err_o), 64'(1));
    check("frame_body_idle_vc", 64'(err_vc_o), 64'(0));
    advance();
    apply(0, 1, 1, make_flit(2'b00), 0); advance();
    apply(0, 1, 1, make_flit(2'b00), 0); advance();
    apply(0, 0, 0, '0, 0);
    check("frame_second_err", 64'(err_o), 64'(1));
    check("frame_second_vc", 64'(err_vc_o), 64'(0));
    $display("framing: err=%b err_vc=%b", err_o, err_vc_o);
    advance();
    do_reset();
    apply(0, 1, 1, make_flit(2'b10), 0); advance();
    apply(0, 1, 0, make_flit(2'b01), 0); advance();
    apply(0, 0, 0, '0, 0);
    check("frame_vc1_err", 64'(err_o), 64'(1));
    check("frame_vc1_vc", 64'(err_vc_o), 64'(1));
    $display("framing: err=%b err_vc=%b", err_o, err_vc_o);
    advance();

    // Reset mid-packet discards stored flits and restarts framing.
    do_reset();
    apply(0, 1, 0, make_flit(2'b00), 0); advance();
    apply(0, 1, 0, make_flit(2'b01), 0); advance();
    apply(0, 1, 0, make_flit(2'b01), 0); advance();
    apply(1, 0, 0, '0, 0); advance();
    apply(0, 0, 0, '0, 1);
    check("rst_mid_req", 64'(out_req_o), 64'(0));
    check("rst_mid_ready", 64'(in_ready_o), 64'(2'b11));
    check("rst_mid_credit", 64'(credit_o), 64'(0));
    check("rst_mid_err", 64'(err_o), 64'(0));
    advance();
    apply(0, 1, 0, make_flit(2'b01), 0); advance();
    apply(0, 0, 0, '0, 0);
    check("rst_body_err", 64'(err_o), 64'(1));
    check("rst_body_vc", 64'(err_vc_o), 64'(0));
    check("rst_body_valid", 64'(out_req_o[VALID_BIT]), 64'(1));
    check("rst_body_type", 64'(out_req_o[TYPE_MSB:TYPE_LSB]), 64'(2'b01));
    $display("reset mid-packet: req=%h ready=%b err=%b", out_req_o, in_ready_o, err_o);
    advance();

    // Random traffic, mostly well-framed, with occasional resets.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      r   = ($urandom_range(0, 149) == 0);
      vld = ($urandom_range(0, 99) < 60);
      ack = ($urandom_range(0, 99) < 50);
      vc  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ty = 2'($urandom_range(0, 3));
      else if (m_in_pkt[vc])         ty = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      else                           ty = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      apply(r, vld, vc, make_flit(ty), ack);
      check_model();
      if (out_ack_i && m_sel_valid && !arst)
        $display("pop: vc=%b flit=%h credit=%b", m_sel_vc, mq[m_sel_vc][0], credit_o);
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
